ex_mdu: RTL

Iterative multiply/divide execute unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU). It sits beside the single-cycle ALU in the EX stage and accepts one operation at a time. It holds the pipeline through `stall_req_o` while it iterates, then delivers a rd writeback bundle to MEM. Throughput and latency are parametrised by the number of result bits retired per cycle.

---
 rtl/ex_mdu_pkg.sv | 34 +++
 rtl/ex_mdu_div_step.sv | 22 ++
 rtl/ex_mdu.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// register widths, RV32M funct3 codes and the MDU state encoding.
package ex_mdu_pkg;

  localparam int RegLen     = 32;
  localparam int RegAddrLen = 5;

  localparam logic [RegLen-1:0] ZERO_WORD = '0;
  localparam logic Enable  = 1'b1;
  localparam logic Disable = 1'b0;

  localparam logic [2:0] MUL    = 3'b000;
  localparam logic [2:0] MULH   = 3'b001;
  localparam logic [2:0] MULHSU = 3'b010;
  localparam logic [2:0] MULHU  = 3'b011;
  localparam logic [2:0] DIV    = 3'b100;
  localparam logic [2:0] DIVU   = 3'b101;
  localparam logic [2:0] REM    = 3'b110;
  localparam logic [2:0] REMU   = 3'b111;

  localparam int MduStateLen = 2;

  typedef enum logic [MduStateLen-1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // Every divide/remainder opcode has funct3[2] set.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/ex_mdu_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor if it fits, and report the resulting quotient bit.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic            dividend_bit_i,
  output logic [XLEN-1:0] rem_o,
  output logic            quot_bit_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  assign shifted    = {rem_i, dividend_bit_i};
  // The low XLEN bits of the difference are exact whenever the subtraction is taken.
  assign diff       = shifted[XLEN-1:0] - divisor_i;
  assign quot_bit_o = (shifted >= {1'b0, divisor_i});
  assign rem_o      = quot_bit_o ? diff : shifted[XLEN-1:0];

endmodule

// File: rtl/ex_mdu.sv
// Iterative RV32M execute unit: shift-add multiply and restoring divide on
// operand magnitudes, retiring BITS_PER_CYCLE bits per cycle, sign fixed at the end.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN           = RegLen,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  start_i,
  input  logic [2:0]            funct3_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic [RegAddrLen-1:0] rd_addr_i,
  input  logic                  flush_i,
  output logic                  stall_req_o,
  output logic                  done_o,
  output logic [XLEN-1:0]       result_o,
  output logic [RegAddrLen-1:0] rd_addr_o,
  output logic                  rd_write_enable_o,
  output logic                  busy_o,
  output mdu_state_e            state_o
);

  localparam int Steps = XLEN / BITS_PER_CYCLE;
  localparam int CntW  = $clog2(Steps) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Steps - 1);

  mdu_state_e            state_q;
  logic [CntW-1:0]       cnt_q;
  logic [2:0]            f3_q;
  logic [RegAddrLen-1:0] rd_q;
  logic [XLEN-1:0]       a_q, b_q, result_q;
  logic [2*XLEN-1:0]     acc_q;
  logic                  neg_q;

  // Start-time operand decode
  logic            rs1_signed, rs2_signed, s1, s2, neg_start;
  logic [XLEN-1:0] mag1, mag2, fast_result_d;
  logic            div_zero, div_ovf, fast_path;

  assign rs1_signed = (funct3_i == MULH) || (funct3_i == MULHSU) ||
                      (funct3_i == DIV)  || (funct3_i == REM);
  assign rs2_signed = (funct3_i == MULH) || (funct3_i == DIV) || (funct3_i == REM);
  assign s1         = rs1_signed & rs1_data_i[XLEN-1];
  assign s2         = rs2_signed & rs2_data_i[XLEN-1];
  assign mag1       = s1 ? -rs1_data_i : rs1_data_i;
  assign mag2       = s2 ? -rs2_data_i : rs2_data_i;
  assign neg_start  = (funct3_i == REM) ? s1 : (s1 ^ s2);

  assign div_zero  = is_div_op(funct3_i) && (rs2_data_i == '0);
  assign div_ovf   = ((funct3_i == DIV) || (funct3_i == REM)) &&
                     (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == '1);
  assign fast_path = div_zero || div_ovf;
  // funct3[1] distinguishes REM/REMU from DIV/DIVU
  assign fast_result_d = div_zero ? (funct3_i[1] ? rs1_data_i : '1)
                                  : (funct3_i[1] ? '0 : rs1_data_i);

  // Multiply: add multiplicand into the high half on each multiplier LSB, shift right.
  logic [2*XLEN-1:0] mul_acc_d;
  logic [XLEN-1:0]   mul_b_d;
  logic [XLEN:0]     mul_sum;

  always_comb begin
    mul_acc_d = acc_q;
    mul_b_d   = b_q;
    mul_sum   = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      mul_sum   = {1'b0, mul_acc_d[2*XLEN-1:XLEN]} + (mul_b_d[0] ? {1'b0, a_q} : '0);
      mul_acc_d = {mul_sum, mul_acc_d[XLEN-1:1]};
      mul_b_d   = mul_b_d >> 1;
    end
  end

  // Divide: acc holds {partial remainder, quotient}; a_q supplies dividend MSBs.
  logic [XLEN-1:0]           rem_chain [BITS_PER_CYCLE+1];
  logic [BITS_PER_CYCLE-1:0] qbits;
  logic [2*XLEN-1:0]         div_acc_d;

  assign rem_chain[0] = acc_q[2*XLEN-1:XLEN];

  for (genvar k = 0; k < BITS_PER_CYCLE; k++) begin : g_div_chain
    mdu_div_step #(.XLEN(XLEN)) u_step (
      .rem_i          (rem_chain[k]),
      .divisor_i      (b_q),
      .dividend_bit_i (a_q[XLEN-1-k]),
      .rem_o          (rem_chain[k+1]),
      .quot_bit_o     (qbits[BITS_PER_CYCLE-1-k])
    );
  end

  assign div_acc_d = {rem_chain[BITS_PER_CYCLE], acc_q[XLEN-BITS_PER_CYCLE-1:0], qbits};

  // Sign fixup and result selection on the final iteration
  logic [2*XLEN-1:0] prod_d;
  logic [XLEN-1:0]   quot_d, rem_d, result_d;

  assign prod_d = neg_q ? -mul_acc_d : mul_acc_d;
  assign quot_d = neg_q ? -div_acc_d[XLEN-1:0] : div_acc_d[XLEN-1:0];
  assign rem_d  = neg_q ? -div_acc_d[2*XLEN-1:XLEN] : div_acc_d[2*XLEN-1:XLEN];

  always_comb begin
    result_d = '0;
    case (f3_q)
      MUL:                  result_d = prod_d[XLEN-1:0];
      MULH, MULHSU, MULHU:  result_d = prod_d[2*XLEN-1:XLEN];
      DIV, DIVU:            result_d = quot_d;
      default:              result_d = rem_d;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      neg_q    <= Disable;
      result_q <= '0;
    end else if (flush_i) begin
      state_q <= MDU_IDLE;
    end else if (rdy_in) begin
      case (state_q)
        MDU_IDLE: begin
          if (start_i) begin
            f3_q  <= funct3_i;
            rd_q  <= rd_addr_i;
            neg_q <= neg_start;
            if (fast_path) begin
              result_q <= fast_result_d;
              state_q  <= MDU_DONE;
            end else begin
              a_q     <= mag1;
              b_q     <= mag2;
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= MDU_CALC;
            end
          end
        end
        MDU_CALC: begin
          if (is_div_op(f3_q)) begin
            acc_q <= div_acc_d;
            a_q   <= a_q << BITS_PER_CYCLE;
          end else begin
            acc_q <= mul_acc_d;
            b_q   <= mul_b_d;
          end
          if (cnt_q == LastCnt) begin
            result_q <= result_d;
            state_q  <= MDU_DONE;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  assign done_o            = (state_q == MDU_DONE);
  assign result_o          = done_o ? result_q : '0;
  assign rd_addr_o         = done_o ? rd_q : '0;
  assign rd_write_enable_o = done_o;
  assign busy_o            = (state_q != MDU_IDLE);
  assign stall_req_o       = ((state_q == MDU_IDLE) && start_i) || (state_q == MDU_CALC);
  assign state_o           = state_q;

endmodule
